serlcd_line_scheduler: RTL

// - Shares the single serial-LCD byte stream between two line writers (row 0, row 1).
// - Per grant it sends the SparkFun cursor command 0xFE, then position byte 0x80|(row*0x40),

---
 rtl/serlcd_line_scheduler.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/serlcd_line_scheduler.sv
// ============================================================================
//  Module      : serlcd_line_scheduler
//  Description : Shares one serial-LCD byte stream between two line writers.
//                For each grant it sends the cursor command 0xFE, the row
//                position byte, waits GAP_CYCLES, then streams LINE_LEN
//                characters from the winner's synchronous line buffer.
//  Ports       : clk_50            system clock, all logic on posedge
//                rst               synchronous active-high reset
//                req[1:0]          line-send requests (row 0, row 1)
//                done[1:0]         one-cycle completion pulse per requester
//                char_addr[3:0]    shared read address into both line buffers
//                char_data0/1[7:0] buffer read data (1-cycle latency)
//                tx_data[7:0]      byte to the UART transmitter
//                tx_valid          tx_data valid (accepted with tx_ready)
//                tx_ready          UART transmitter can take a byte
//                busy              high whenever a transfer is in progress
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module serlcd_line_scheduler #(
  parameter int unsigned LINE_LEN   = 16,
  parameter int unsigned GAP_CYCLES = 50000
) (
  input  logic       clk_50,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] done,
  output logic [3:0] char_addr,
  input  logic [7:0] char_data0,
  input  logic [7:0] char_data1,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  // The counter keeps at least one bit so a zero gap still elaborates.
  localparam int unsigned            c_GAP_W     = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [c_GAP_W-1:0]     c_GAP_LAST  = (GAP_CYCLES > 0) ? c_GAP_W'(GAP_CYCLES - 1) : '0;
  localparam logic [3:0]             c_LAST_ADDR = 4'(LINE_LEN - 1);
  localparam logic [7:0]             c_CMD_BYTE  = 8'hFE;
  localparam logic [7:0]             c_POS_ROW0  = 8'h80;
  localparam logic [7:0]             c_POS_ROW1  = 8'hC0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_POS   = 3'd2,
    S_GAP   = 3'd3,
    S_FETCH = 3'd4,
    S_WAIT  = 3'd5,
    S_SEND  = 3'd6,
    S_FIN   = 3'd7
  } state_t;

  state_t               r_state,     w_state_nx;
  logic                 r_sel,       w_sel_nx;
  logic                 r_rr_last,   w_rr_last_nx;
  logic [c_GAP_W-1:0]   r_gap_cnt,   w_gap_cnt_nx;
  logic [3:0]           r_char_addr, w_char_addr_nx;
  logic [7:0]           r_tx_data,   w_tx_data_nx;
  logic                 r_tx_valid,  w_tx_valid_nx;
  logic [1:0]           r_done,      w_done_nx;
  logic                 w_accept;

  // A handshake only counts when a byte is actually offered.
  assign w_accept = r_tx_valid & tx_ready;

  always_comb begin
    w_state_nx     = r_state;
    w_sel_nx       = r_sel;
    w_rr_last_nx   = r_rr_last;
    w_gap_cnt_nx   = r_gap_cnt;
    w_char_addr_nx = r_char_addr;
    w_tx_data_nx   = r_tx_data;
    w_tx_valid_nx  = r_tx_valid;
    w_done_nx      = 2'b00;

    case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          // Single requester wins outright; a tie goes to the row not served last.
          w_sel_nx      = (req == 2'b11) ? ~r_rr_last : req[1];
          w_rr_last_nx  = w_sel_nx;
          w_tx_data_nx  = c_CMD_BYTE;
          w_tx_valid_nx = 1'b1;
          w_state_nx    = S_CMD;
        end
      end

      S_CMD: begin
        if (w_accept) begin
          w_tx_data_nx = r_sel ? c_POS_ROW1 : c_POS_ROW0;
          w_state_nx   = S_POS;
        end
      end

      S_POS: begin
        if (w_accept) begin
          w_tx_valid_nx = 1'b0;
          if (GAP_CYCLES == 0) begin
            w_char_addr_nx = 4'd0;
            w_state_nx     = S_FETCH;
          end else begin
            w_gap_cnt_nx = '0;
            w_state_nx   = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (r_gap_cnt == c_GAP_LAST) begin
          w_char_addr_nx = 4'd0;
          w_state_nx     = S_FETCH;
        end else begin
          w_gap_cnt_nx = r_gap_cnt + c_GAP_W'(1);
        end
      end

      // char_addr is already presented; the buffer returns data one cycle later.
      S_FETCH: w_state_nx = S_WAIT;

      S_WAIT: begin
        w_tx_data_nx  = r_sel ? char_data1 : char_data0;
        w_tx_valid_nx = 1'b1;
        w_state_nx    = S_SEND;
      end

      S_SEND: begin
        if (w_accept) begin
          w_tx_valid_nx = 1'b0;
          if (r_char_addr == c_LAST_ADDR) begin
            w_done_nx  = r_sel ? 2'b10 : 2'b01;
            w_state_nx = S_FIN;
          end else begin
            w_char_addr_nx = r_char_addr + 4'd1;
            w_state_nx     = S_FETCH;
          end
        end
      end

      S_FIN: begin
        w_char_addr_nx = 4'd0;
        w_state_nx     = S_IDLE;
      end

      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sel       <= 1'b0;
      r_rr_last   <= 1'b1;
      r_gap_cnt   <= '0;
      r_char_addr <= 4'd0;
      r_tx_data   <= 8'h00;
      r_tx_valid  <= 1'b0;
      r_done      <= 2'b00;
    end else begin
      r_state     <= w_state_nx;
      r_sel       <= w_sel_nx;
      r_rr_last   <= w_rr_last_nx;
      r_gap_cnt   <= w_gap_cnt_nx;
      r_char_addr <= w_char_addr_nx;
      r_tx_data   <= w_tx_data_nx;
      r_tx_valid  <= w_tx_valid_nx;
      r_done      <= w_done_nx;
    end
  end

  assign done      = r_done;
  assign char_addr = r_char_addr;
  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
